// File: rtl/aura_fifo_pkg.sv
// aura_fifo_pkg: shared types and helpers for the SRAM-backed stream queues
package aura_fifo_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int unsigned fifo_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// fifo_out_reg: one-entry registered output stage with load/consume control
module fifo_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // A load refills the slot even while it is being consumed; a bare consume only drops valid.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO sequencer around an external 1W1R storage array
module sram_fifo_ctrl
    import aura_fifo_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int CW          = $clog2(DEPTH + 2),
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_re,
    output logic [AW-1:0]    mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             afull
);

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] mcount;
    logic          out_vld, enq_fire, load;
    hs_t           enq_hs;

    assign enq_ready = mcount != CW'(DEPTH);
    assign enq_hs    = '{valid: enq_valid, ready: enq_ready};
    assign enq_fire  = enq_hs.valid & enq_hs.ready & ~flush;
    assign load      = (mcount != '0) & (~out_vld | deq_ready) & ~flush;

    assign mem_we    = enq_fire;
    assign mem_waddr = wptr;
    assign mem_wdata = enq_data;
    assign mem_re    = load;
    assign mem_raddr = rptr;

    assign deq_valid = out_vld;
    assign count     = mcount + CW'(out_vld);
    assign empty     = count == '0;
    assign afull     = count >= CW'(AFULL_THRESH);

    // Pointers and array occupancy; mcount alone decides full/empty.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr   <= '0;
            rptr   <= '0;
            mcount <= '0;
        end else begin
            if (enq_fire) wptr <= AW'(fifo_ptr_inc(32'(wptr), DEPTH));
            if (load) rptr <= AW'(fifo_ptr_inc(32'(rptr), DEPTH));
            mcount <= mcount + CW'(enq_fire) - CW'(load);
        end
    end

    fifo_out_reg #(.WIDTH(WIDTH)) u_out (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .load      (load),
        .load_data (mem_rdata),
        .ready     (deq_ready),
        .valid     (out_vld),
        .data      (deq_data)
    );

`ifdef GEN_ASSERT
    a_mcount_max: assert property (@(posedge clock) mcount <= CW'(DEPTH));
    a_no_enq_full: assert property (@(posedge clock) !(enq_fire && mcount == CW'(DEPTH)));
    a_deq_stable: assert property (@(posedge clock) disable iff (reset)
        (deq_valid && !deq_ready && !flush) |=> $stable(deq_data));
    a_ptr_range: assert property (@(posedge clock) 32'(rptr) < DEPTH && 32'(wptr) < DEPTH);
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed vector bench for sram_fifo_ctrl with DEPTH=4, AFULL_THRESH=3
module tb_sram_fifo_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 2);
    localparam int AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset, flush, enq_valid, deq_ready;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready, deq_valid, mem_we, mem_re, empty, afull;
    logic [WIDTH-1:0] deq_data, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_waddr, mem_raddr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];

    typedef struct {
        logic        rst, fl, ev;
        logic [31:0] ed;
        logic        dr, er, dv;
        logic [31:0] dd;
        int          cnt;
        logic        af, we;
    } vec_t;

    vec_t vq[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clock = ~clock;

    // Storage array with combinational read, write visible from the next cycle.
    always @(posedge clock) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .count     (count),
        .empty     (empty),
        .afull     (afull)
    );

    task automatic chk(input string n, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0d: got %0h expected %0h", n, idx, act, exp);
    endtask

    task automatic v(input logic rst, fl, ev, input logic [31:0] ed, input logic dr, er, dv,
                     input logic [31:0] dd, input int cnt, input logic af, we);
        vec_t e;
        e = '{rst: rst, fl: fl, ev: ev, ed: ed, dr: dr, er: er, dv: dv, dd: dd, cnt: cnt, af: af, we: we};
        vq.push_back(e);
    endtask

    initial begin
        // rst fl ev  ed     dr | er dv dd     cnt af we
        v(0, 0, 1, 'hA1, 0,  1, 0, 0,     0, 0, 1);
        v(0, 0, 0, 0,    0,  1, 0, 0,     1, 0, 0);
        v(0, 0, 0, 0,    0,  1, 1, 'hA1,  1, 0, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'hA1,  1, 0, 0);
        v(0, 0, 0, 0,    0,  1, 0, 'hA1,  0, 0, 0);
        v(0, 0, 1, 'h10, 0,  1, 0, 'hA1,  0, 0, 1);
        v(0, 0, 1, 'h11, 0,  1, 0, 'hA1,  1, 0, 1);
        v(0, 0, 1, 'h12, 0,  1, 1, 'h10,  2, 0, 1);
        v(0, 0, 1, 'h13, 0,  1, 1, 'h10,  3, 1, 1);
        v(0, 0, 1, 'h14, 0,  1, 1, 'h10,  4, 1, 1);
        v(0, 0, 1, 'h15, 0,  0, 1, 'h10,  5, 1, 0);
        v(0, 0, 0, 0,    1,  0, 1, 'h10,  5, 1, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h11,  4, 1, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h12,  3, 1, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h13,  2, 0, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h14,  1, 0, 0);
        v(0, 0, 0, 0,    0,  1, 0, 'h14,  0, 0, 0);
        v(0, 0, 1, 'h20, 0,  1, 0, 'h14,  0, 0, 1);
        v(0, 0, 1, 'h21, 0,  1, 0, 'h14,  1, 0, 1);
        v(0, 0, 1, 'h22, 0,  1, 1, 'h20,  2, 0, 1);
        v(0, 0, 1, 'h23, 0,  1, 1, 'h20,  3, 1, 1);
        v(0, 0, 1, 'h24, 0,  1, 1, 'h20,  4, 1, 1);
        v(0, 0, 1, 'h25, 1,  0, 1, 'h20,  5, 1, 0);
        v(0, 0, 1, 'h25, 1,  1, 1, 'h21,  4, 1, 1);
        v(0, 0, 0, 0,    1,  1, 1, 'h22,  4, 1, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h23,  3, 1, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h24,  2, 0, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h25,  1, 0, 0);
        v(0, 0, 0, 0,    0,  1, 0, 'h25,  0, 0, 0);
        v(0, 0, 1, 'h30, 0,  1, 0, 'h25,  0, 0, 1);
        v(0, 0, 1, 'h31, 0,  1, 0, 'h25,  1, 0, 1);
        v(0, 0, 1, 'h32, 0,  1, 1, 'h30,  2, 0, 1);
        v(0, 1, 1, 'h33, 0,  1, 1, 'h30,  3, 1, 0);
        v(0, 0, 1, 'h55, 0,  1, 0, 0,     0, 0, 1);
        v(0, 0, 0, 0,    0,  1, 0, 0,     1, 0, 0);
        v(0, 0, 0, 0,    1,  1, 1, 'h55,  1, 0, 0);
        v(0, 0, 0, 0,    0,  1, 0, 'h55,  0, 0, 0);
        v(0, 0, 1, 'h40, 0,  1, 0, 'h55,  0, 0, 1);
        v(0, 0, 1, 'h41, 0,  1, 0, 'h55,  1, 0, 1);
        v(1, 0, 0, 0,    0,  1, 1, 'h40,  2, 0, 0);
        v(0, 0, 0, 0,    0,  1, 0, 0,     0, 0, 0);
        v(0, 0, 0, 0,    1,  1, 0, 0,     0, 0, 0);

        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
        repeat (2) @(posedge clock);

        foreach (vq[i]) begin
            @(negedge clock);
            reset = vq[i].rst; flush = vq[i].fl; enq_valid = vq[i].ev;
            enq_data = vq[i].ed; deq_ready = vq[i].dr;
            #1;
            chk("enq_ready", i, 32'(enq_ready), 32'(vq[i].er));
            chk("deq_valid", i, 32'(deq_valid), 32'(vq[i].dv));
            chk("deq_data",  i, deq_data, vq[i].dd);
            chk("count",     i, 32'(count), 32'(vq[i].cnt));
            chk("empty",     i, 32'(empty), 32'(vq[i].cnt == 0));
            chk("afull",     i, 32'(afull), 32'(vq[i].af));
            chk("mem_we",    i, 32'(mem_we), 32'(vq[i].we));
        end

        // Streaming: 20 cycles of enq and deq together, then drain.
        for (int k = 0; k < 23; k++) begin
            @(negedge clock);
            reset = 1'b0; flush = 1'b0;
            enq_valid = (k < 20); enq_data = 32'h100 + 32'(k); deq_ready = 1'b1;
            #1;
            if (k >= 2 && k < 22) begin
                chk("stream_valid", k, 32'(deq_valid), 32'd1);
                chk("stream_data",  k, deq_data, 32'h100 + 32'(k - 2));
                chk("stream_count", k, 32'(count), (k < 21) ? 32'd2 : 32'd1);
            end else begin
                chk("stream_valid", k, 32'(deq_valid), 32'd0);
                chk("stream_count", k, 32'(count), (k == 1) ? 32'd1 : 32'd0);
            end
            if (k < 20) chk("stream_we", k, 32'(mem_we), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Sequencing controller that turns the single-write, single-read SRAM storage array into a valid/ready FIFO for the attention datapath, e.g. for K/V row streaming between the tile loader and the dot-product engine.
- Owns the write and read pointers, the occupancy count and the full/empty flags, and a one-entry registered output stage.
- The storage array is a separate instance; this block drives its write port and one read port.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, storage array entries; must be >= 2; need not be a power of two.
- AFULL_THRESH, DEPTH-2, total occupancy at or above which afull asserts.
- CW (localparam), $clog2(DEPTH+2), count width.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- enq_valid  in  1  producer has a word.
- enq_ready  out  1  controller accepts a word this cycle.
- enq_data  in  WIDTH  producer word.
- deq_valid  out  1  output register holds a word.
- deq_ready  in  1  consumer takes the word this cycle.
- deq_data  out  WIDTH  output register contents.
- mem_we  out  1  storage write enable.
- mem_waddr  out  AW  storage write address.
- mem_wdata  out  WIDTH  storage write data.
- mem_re  out  1  storage read enable, port 0.
- mem_raddr  out  AW  storage read address, port 0.
- mem_rdata  in  WIDTH  storage combinational read data, port 0.
- count  out  CW  total words held (array + output register), 0..DEPTH+1.
- empty  out  1  count == 0.
- afull  out  1  count >= AFULL_THRESH.

Behaviour:
- State: wptr, rptr (AW bits each), mcount (words in array, 0..DEPTH), out_vld, out_data.
- Reset or flush: wptr=rptr=0, mcount=0, out_vld=0, out_data=0. Outputs after reset: enq_ready=1, deq_valid=0, deq_data=0, count=0, empty=1, afull=0 (for AFULL_THRESH>0).
- Flush has priority over enq and deq in the same cycle. Any enq or deq handshake in a flush cycle is dropped.
- enq_ready = (mcount != DEPTH). It is combinational from state only and never depends on deq_ready.
- Enqueue fire = enq_valid & enq_ready. On fire:
  - mem_we=1, mem_waddr=wptr, mem_wdata=enq_data.
  - wptr advances; it wraps from DEPTH-1 to 0.
- mem_we=0 when no fire. mem_waddr and mem_wdata then hold wptr and enq_data; their values are don't-care.
- Deq fire = deq_valid & deq_ready. deq_valid = out_vld and deq_data = out_data, both straight from flops.
- Load condition:
  - load = (mcount != 0) & (!out_vld | deq_ready).
  - mem_re = load and mem_raddr = rptr; rptr is driven every cycle.
  - On load: out_data <= mem_rdata, out_vld <= 1, rptr advances with wrap.
  - Else, if deq fire: out_vld <= 0, and out_data holds its value.
- Array write-to-read bypass is not used. A word written at edge t is readable from cycle t+1.
- Latency: enqueue at edge t into an empty FIFO -> deq_valid=1 in cycle t+2.
- Throughput is 1 word/cycle in steady state; there are no bubbles when deq_ready=1 continuously.
- mcount next = mcount + enq_fire - load. A simultaneous write and load leaves mcount unchanged.
- count = mcount + out_vld.
- Full boundary: mcount == DEPTH gives enq_ready=0, even if a load happens in that cycle. Capacity is DEPTH+1.
- Empty boundary: mcount == 0 gives no load. Enqueue and deq in the same cycle with out_vld=1 and mcount=0 gives:
  - out_vld -> 0;
  - the new word appears two cycles after the enqueue edge.
- Pointer equality is not used for full/empty; mcount is authoritative.
- enq_data is ignored when enq_valid=0. deq_ready is ignored when deq_valid=0.
- Assertions under GEN_ASSERT:
  - mcount <= DEPTH;
  - no enq fire while mcount == DEPTH;
  - deq_data stable while deq_valid & !deq_ready;
  - rptr and wptr < DEPTH.

Decomposition:
- Shared package aura_fifo_pkg:
  - function fifo_ptr_inc(ptr, depth) implementing the wrap increment;
  - a typedef for the handshake pair struct {valid, ready}, reused by the other stream controllers.
- Sub-module fifo_out_reg: the one-entry output register with load/consume control. It is natural, and is reused by other SRAM-backed queues.
- The storage array is instantiated alongside, not inside, this block.

Test Plan:
- Reset release, then DEPTH=4, enqueue 0xA1 at edge 1 with deq_ready=0 -> deq_valid=1 from cycle 3, deq_data=0xA1, count=1, empty=0.
- Enqueue 0x10..0x14 back-to-back with deq_ready=0 -> count reaches 5, then enq_ready=0 with mcount=4. A 6th enqueue is held with no mem_we. Drain yields 0x10..0x14 in order.
- Continuous enq_valid=1 and deq_ready=1 for 20 cycles with incrementing data -> one word out per cycle after the 2-cycle fill, in order. Pointers wrap 3->0 several times and count stays at 2.
- Full FIFO with deq_ready=1 and enq_valid=1 in the same cycle -> enq_ready=0 in that cycle, then 1 in the next cycle, with no word lost or duplicated.
- Flush asserted with count=3 and enq_valid=1 -> next cycle count=0, deq_valid=0, empty=1, and the enqueued word is not delivered. The following enqueue of 0x55 is delivered first.
- AFULL_THRESH=3 -> afull rises when count goes 2->3 and falls on the dequeue that makes count 2. Reset asserted mid-stream clears all outputs to their reset values the next cycle.
